// File: rtl/spi_slave_responder.sv
// SPI slave: oversamples sclk/cs/mosi in the clk domain, receives WIDTH-bit MOSI frames
// and answers MSB-first on miso from a one-entry holding register. Option: SPI_RESP_ECHO_EN.
module spi_slave_responder #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             sclk_i,
  input  logic             cs_i,
  input  logic             mosi_i,
  output logic             miso_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_done_o,
  output logic             tx_underrun_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_last_q, cs_last_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  // The final bit comes straight from mosi_s, so only WIDTH-1 bits are buffered.
  logic [WIDTH-2:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             rx_done_q, rx_done_d;
  logic             underrun_q, underrun_d;
  logic [WIDTH-1:0] fill_word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_last_q;
  assign sclk_fall = ~sclk_s & sclk_last_q;
  assign cs_rise   = cs_s & ~cs_last_q;
  assign cs_fall   = ~cs_s & cs_last_q;

`ifdef SPI_RESP_ECHO_EN
  assign fill_word = rx_data_q;
`else
  assign fill_word = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_done_d   = 1'b0;
    underrun_d  = 1'b0;

    // A load and a write cannot both hit a full register: writes need it empty.
    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_rise) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          if (hold_full_q) begin
            tx_sh_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            tx_sh_d    = fill_word;
            underrun_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_fall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[WIDTH-3:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            rx_data_d = {rx_sh_q, mosi_s};
            rx_done_d = 1'b1;
            state_d   = ST_DONE;
          end
        end else if (sclk_fall && cnt_q < CW'(WIDTH)) begin
          tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = cs_s ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_last_q <= 1'b0;
      cs_last_q   <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_last_q <= sclk_s;
      cs_last_q   <= cs_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_done_q   <= rx_done_d;
      underrun_q  <= underrun_d;
    end
  end

  // miso is forced low outside SHIFT so abort, DONE and reset all idle the line.
  assign miso_o        = (state_q == ST_SHIFT) & tx_sh_q[WIDTH-1];
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_done_o     = rx_done_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a behavioural SPI master (6-clk half period)
// drives frames while pulse counters track rx_done and tx_underrun.
module tb_spi_slave_responder;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset_n, sclk, cs, mosi, miso;
  logic         tx_valid, tx_ready, rx_done, tx_underrun;
  logic [W-1:0] tx_data, rx_data;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int unr_cnt  = 0;

`ifdef SPI_RESP_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  spi_slave_responder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_ni(reset_n), .sclk_i(sclk), .cs_i(cs), .mosi_i(mosi),
    .miso_o(miso), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_done_o(rx_done), .tx_underrun_o(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_done) done_cnt++;
    if (tx_underrun) unr_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One bit: low half with mosi set, sample miso, rise, high half (leaves sclk high).
  task automatic spi_bit(input logic b, output logic m);
    sclk = 1'b0;
    mosi = b;
    wait_clk(6);
    m    = miso;
    sclk = 1'b1;
    wait_clk(6);
  endtask

  task automatic spi_frame(input logic [W-1:0] mo, input int nbits, input bit push_mid,
                           input logic [W-1:0] mid, output logic [W-1:0] mi);
    mi = '0;
    cs = 1'b1;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      logic m;
      spi_bit(mo[W-1-i], m);
      mi[W-1-i] = m;
      if (push_mid && i == 3) push(mid);
    end
    sclk = 1'b0;
    wait_clk(6);
    cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_reset;
    n_checks += 5;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", miso); end
    if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data got %h want 000", rx_data); end
    if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done got %b want 0", rx_done); end
    if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", tx_underrun); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_basic;
    logic [W-1:0] mi;
    int d0, u0;
    push(12'hA5C);
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_low got %b want 0", tx_ready); end
    d0 = done_cnt; u0 = unr_cnt;
    spi_frame(12'h3F1, W, 1'b0, '0, mi);
    n_checks += 5;
    if (mi !== 12'hA5C) begin n_fail++; $display("FAIL basic_miso got %h want a5c", mi); end
    if (rx_data !== 12'h3F1) begin n_fail++; $display("FAIL basic_rx_data got %h want 3f1", rx_data); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_rx_done got %0d want 1", done_cnt - d0); end
    if (unr_cnt - u0 !== 0) begin n_fail++; $display("FAIL basic_underrun got %0d want 0", unr_cnt - u0); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_high got %b want 1", tx_ready); end
  endtask

  task automatic test_underrun;
    logic [W-1:0] mi, exp;
    int d0, u0;
    exp = ECHO ? 12'h3F1 : 12'h000;
    d0 = done_cnt; u0 = unr_cnt;
    spi_frame(12'h5A5, W, 1'b0, '0, mi);
    n_checks += 4;
    if (mi !== exp) begin n_fail++; $display("FAIL underrun_miso got %h want %h", mi, exp); end
    if (unr_cnt - u0 !== 1) begin n_fail++; $display("FAIL underrun_pulse got %0d want 1", unr_cnt - u0); end
    if (rx_data !== 12'h5A5) begin n_fail++; $display("FAIL underrun_rx_data got %h want 5a5", rx_data); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL underrun_rx_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] mi1, mi2;
    int d0, u0;
    push(12'hABC);
    d0 = done_cnt; u0 = unr_cnt;
    spi_frame(12'h001, W, 1'b1, 12'h123, mi1);
    spi_frame(12'h800, W, 1'b0, '0, mi2);
    n_checks += 6;
    if (mi1 !== 12'hABC) begin n_fail++; $display("FAIL b2b_miso1 got %h want abc", mi1); end
    if (mi2 !== 12'h123) begin n_fail++; $display("FAIL b2b_miso2 got %h want 123", mi2); end
    if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_rx_done got %0d want 2", done_cnt - d0); end
    if (unr_cnt - u0 !== 0) begin n_fail++; $display("FAIL b2b_underrun got %0d want 0", unr_cnt - u0); end
    if (rx_data !== 12'h800) begin n_fail++; $display("FAIL b2b_rx_data got %h want 800", rx_data); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_abort;
    logic [W-1:0] mi;
    int d0;
    push(12'h777);
    d0 = done_cnt;
    spi_frame(12'h0F0, 5, 1'b0, '0, mi);
    n_checks += 4;
    if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_rx_done got %0d want 0", done_cnt - d0); end
    if (rx_data !== 12'h800) begin n_fail++; $display("FAIL abort_rx_data got %h want 800", rx_data); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", tx_ready); end
    if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso_idle got %b want 0", miso); end
    push(12'h456);
    d0 = done_cnt;
    spi_frame(12'hFFF, W, 1'b0, '0, mi);
    n_checks += 3;
    if (mi !== 12'h456) begin n_fail++; $display("FAIL abort_next_miso got %h want 456", mi); end
    if (rx_data !== 12'hFFF) begin n_fail++; $display("FAIL abort_next_rx got %h want fff", rx_data); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL abort_next_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_hold_full;
    logic [W-1:0] mi, exp;
    int u0;
    push(12'h9E7);
    tx_data  = 12'h111;
    tx_valid = 1'b1;
    wait_clk(5);
    n_checks++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready got %b want 0", tx_ready); end
    tx_valid = 1'b0;
    u0 = unr_cnt;
    spi_frame(12'h0C3, W, 1'b0, '0, mi);
    n_checks += 2;
    if (mi !== 12'h9E7) begin n_fail++; $display("FAIL hold_miso got %h want 9e7", mi); end
    if (unr_cnt - u0 !== 0) begin n_fail++; $display("FAIL hold_underrun got %0d want 0", unr_cnt - u0); end
    exp = ECHO ? 12'h0C3 : 12'h000;
    spi_frame(12'h024, W, 1'b0, '0, mi);
    n_checks += 2;
    if (mi !== exp) begin n_fail++; $display("FAIL hold_second_miso got %h want %h", mi, exp); end
    if (unr_cnt - u0 !== 1) begin n_fail++; $display("FAIL hold_second_underrun got %0d want 1", unr_cnt - u0); end
  endtask

  task automatic test_reset_midframe;
    logic [W-1:0] mi;
    logic m;
    int d0, u0;
    push(12'h321);
    cs = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 7; i++) spi_bit(1'b1, m);
    #2 reset_n = 1'b0;
    #1;
    n_checks += 5;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL mid_reset_miso got %b want 0", miso); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got %b want 1", tx_ready); end
    if (rx_data !== '0) begin n_fail++; $display("FAIL mid_reset_rx_data got %h want 000", rx_data); end
    if (rx_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rx_done got %b want 0", rx_done); end
    if (tx_underrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_underrun got %b want 0", tx_underrun); end
    sclk = 1'b0;
    cs   = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(4);
    push(12'h2AB);
    d0 = done_cnt; u0 = unr_cnt;
    spi_frame(12'h135, W, 1'b0, '0, mi);
    n_checks += 4;
    if (mi !== 12'h2AB) begin n_fail++; $display("FAIL post_reset_miso got %h want 2ab", mi); end
    if (rx_data !== 12'h135) begin n_fail++; $display("FAIL post_reset_rx got %h want 135", rx_data); end
    if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL post_reset_done got %0d want 1", done_cnt - d0); end
    if (unr_cnt - u0 !== 0) begin n_fail++; $display("FAIL post_reset_underrun got %0d want 0", unr_cnt - u0); end
  endtask

  initial begin
    reset_n  = 1'b0;
    sclk     = 1'b0;
    cs       = 1'b0;
    mosi     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2);
    test_reset;
    test_basic;
    test_underrun;
    test_back_to_back;
    test_abort;
    test_hold_full;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

- Full-duplex SPI slave, sitting on the `cs`/`sclk`/`mosi` lines driven by `spi_master`.
- Captures each 12-bit MOSI frame MSB-first and drives a 12-bit response word MSB-first on `miso`.
- All SPI inputs are oversampled in the system `clk` domain; a one-entry transmit holding register lets the next response be queued while a frame is in flight.

## Interface
- `WIDTH`, 12: frame length in bits (same for rx and tx).
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `cs`, `mosi`; legal 2..3.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `sclk` in 1: SPI clock from master, asynchronous to `clk`.
- `cs` in 1: chip select, active-high.
- `mosi` in 1: master-out data.
- `miso` out 1: slave-out data.
- `tx_data` in WIDTH: response word to queue.
- `tx_valid` in 1: `tx_data` valid; accepted when `tx_valid && tx_ready`.
- `tx_ready` out 1: holding register empty.
- `rx_data` out WIDTH: last complete received frame.
- `rx_done` out 1: one-`clk` pulse, `rx_data` updated.
- `tx_underrun` out 1: one-`clk` pulse, frame started with empty holding register.

## Operation
- Reset values:
  - `miso`=0, `rx_data`=0, `rx_done`=0, `tx_underrun`=0, `tx_ready`=1.
  - Holding register empty; state IDLE; bit counter 0.
- Inputs pass through `SYNC_STAGES` flops. Edges are detected on synchronized `sclk` and `cs` against one extra registered copy.
- States:
  - **IDLE**: `miso`=0. On `cs` rise, go to SHIFT:
    - tx shift register loads the holding register if full (holding becomes empty, `tx_ready`→1).
    - Otherwise it loads the fill word and `tx_underrun` pulses.
    - `miso` = tx shift MSB.
  - **SHIFT**:
    - On each `sclk` rise: shift synchronized `mosi` into rx shift LSB; counter+1.
    - On each `sclk` fall: if counter < WIDTH, shift tx register left, `miso` = new MSB.
    - When counter reaches WIDTH on a rise, go to DONE.
  - **DONE**: `rx_data` ← rx shift; `rx_done`=1 for one cycle; `miso`=0; counter=0.
    - Go to IDLE if `cs` is low, else go to WAIT.
  - **WAIT**: ignore `sclk` until `cs` falls, then go to IDLE. Extra clocks inside one `cs` window start no new frame.
- Holding register:
  - Accepted in any state when `tx_ready`=1.
  - A write on the same cycle as a `cs`-rise load goes to the holding register (the load sees the old contents), and `tx_ready` drops.
- Abort:
  - `cs` fall in SHIFT before WIDTH bits → IDLE.
  - No `rx_done`; `rx_data` unchanged; counter cleared; `miso`=0.
  - Consumed tx word is discarded.
- Reset mid-frame: all state returns to reset values immediately; the holding register is emptied.

## Timing
- `sclk`/`cs` edge to internal action: `SYNC_STAGES`+1 `clk` cycles.
- Required `sclk` high and low time ≥ `SYNC_STAGES`+2 `clk`. The `spi_master` 6-`clk` half-period satisfies this.
- `miso` first bit valid `SYNC_STAGES`+2 `clk` after `cs` rise, i.e. before the master's first `sclk` rise.
- `rx_done` asserts 1 `clk` after the WIDTH-th detected `sclk` rise (DONE cycle) and lasts exactly 1 `clk`.
- `tx_ready` rises the cycle after the `cs`-rise load; it falls the cycle after an accepted write.

## Configuration
- Macro: `SPI_RESP_ECHO_EN`.
- Defined: fill word on underrun = current `rx_data` (echo of previous frame, 0 after reset).
- Undefined: fill word = all zeros. `tx_underrun` behaves identically in both builds.

## Test plan
- Queue `tx_data`=12'hA5C, then a frame with master sending 12'h3F1 → `miso` bits read 12'hA5C MSB-first; `rx_data`=12'h3F1; one `rx_done` pulse; `tx_ready`=1 after `cs` rise.
- Two back-to-back frames (12'h001, 12'h800), second tx word 12'h123 written mid-first-frame → responses 12'hABC then 12'h123; two `rx_done` pulses; no underrun.
- Frame with empty holding register → `tx_underrun` pulse.
  - Without the macro, `miso` = 12'h000.
  - With `SPI_RESP_ECHO_EN`, `miso` = previous `rx_data` (12'h3F1).
- `cs` dropped after 5 of 12 bits → no `rx_done`; `rx_data` holds prior value; next full frame 12'hFFF received correctly.
- `reset` low during bit 7 → all outputs at reset values within the same cycle; `tx_ready`=1; next frame starts cleanly from bit 0.
- `tx_valid` held with `tx_ready`=0 (holding full) → second word not accepted; first word transmitted unchanged.
